// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for mem_arbiter; the anti-starvation option is enabled by MEM_ARB_ANTISTARVE_EN
package mem_arbiter_pkg;
  localparam int WORD_W = 32;
  localparam int MBE_W = WORD_W / 8;
  localparam logic [MBE_W-1:0] MBE_ALL = '1;
  typedef logic [WORD_W-1:0] rv32i_word;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, DONE = 2'd3} arb_state_t;
  typedef struct packed {
    rv32i_word addr;
    rv32i_word wdata;
    logic [MBE_W-1:0] mbe;
    logic rd;
    logic wr;
  } mem_req_t;
endpackage

// File: rtl/mem_arbiter_req_reg.sv
// mem_req_reg: enable-loaded register holding the granted memory request
import mem_arbiter_pkg::*;
module mem_req_reg (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  mem_req_t d,
  output mem_req_t q
);
  always_ff @(posedge clk) q <= !rst ? '0 : en ? d : q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and LSQ ports onto one shared memory port, data first
// Define MEM_ARB_ANTISTARVE_EN to force a waiting fetch after STARVE_LIMIT data grants.
import mem_arbiter_pkg::*;
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_read,
  input  logic [ADDR_W-1:0]   instr_mem_address,
  output logic                instr_mem_resp,
  output logic [DATA_W-1:0]   instr_mem_rdata,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W/8-1:0] data_mbe,
  input  logic [ADDR_W-1:0]   data_mem_address,
  input  logic [DATA_W-1:0]   data_mem_wdata,
  output logic                data_mem_resp,
  output logic [DATA_W-1:0]   data_mem_rdata,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [DATA_W/8-1:0] pmem_mbe,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  input  logic                pmem_resp,
  input  logic [DATA_W-1:0]   pmem_rdata
);
  localparam int MW = DATA_W / 8;
  arb_state_t state, state_n;
  mem_req_t req_d, req_q;
  logic data_req, force_i, grant_d, grant_i, busy, idle;
  assign data_req = data_read | data_write;
  assign idle = state == IDLE;
  assign busy = state == BUSY_I || state == BUSY_D;
`ifdef MEM_ARB_ANTISTARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  assign force_i = instr_read & data_req & (starve_cnt == CW'(STARVE_LIMIT));
  always_ff @(posedge clk)
    if (!rst) starve_cnt <= '0;
    else if (idle && grant_i) starve_cnt <= '0;
    else if (idle && grant_d && instr_read && starve_cnt != CW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_i = 1'b0;
`endif
  assign grant_d = data_req & ~force_i;
  assign grant_i = instr_read & (~data_req | force_i);
  always_comb begin
    req_d = '0;
    req_d.addr = grant_d ? rv32i_word'(data_mem_address) : rv32i_word'(instr_mem_address);
    req_d.wdata = grant_d ? rv32i_word'(data_mem_wdata) : '0;
    req_d.mbe = (grant_d && data_write) ? MBE_W'(data_mbe) : MBE_ALL;
    req_d.rd = grant_d ? data_read : 1'b1;
    req_d.wr = grant_d & data_write;
  end
  mem_req_reg u_req (
    .clk (clk),
    .rst (rst),
    .en  (idle & (grant_d | grant_i)),
    .d   (req_d),
    .q   (req_q)
  );
  // DONE is a forced gap so the requester can drop its request before re-arbitration
  always_comb
    state_n = idle ? (grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE)
            : (state == DONE) ? IDLE
            : pmem_resp ? DONE : state;
  always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
  assign pmem_read = busy & req_q.rd;
  assign pmem_write = busy & req_q.wr;
  assign pmem_mbe = busy ? MW'(req_q.mbe) : '0;
  assign pmem_address = busy ? ADDR_W'(req_q.addr) : '0;
  assign pmem_wdata = busy ? DATA_W'(req_q.wdata) : '0;
  assign instr_mem_resp = (state == BUSY_I) & pmem_resp & instr_read;
  assign data_mem_resp = (state == BUSY_D) & pmem_resp;
  assign instr_mem_rdata = instr_mem_resp ? pmem_rdata : '0;
  assign data_mem_rdata = data_mem_resp ? pmem_rdata : '0;
endmodule
